ball_engine: RTL and testbench
==============================

# ball_engine

Parametrised bouncing-ball motion engine for the VGA game datapath. Keeps ball position inside a configurable playfield, with per-axis velocity latched at serve time and a programmable tick divider. Reports bounce and miss events to the score/sound logic. Optionally substitutes a paddle for the bottom wall. Outputs feed the pixel renderer directly.

## Interface
- `COORD_W`, 11: width of x/y coordinates and paddle position.
- `VEL_W`, 3: width of per-axis speed magnitude.
- `DIV`, 262144: clock cycles per motion tick (≥2).
- `X_MIN`, 30 / `X_MAX`, 610: horizontal bounds, inclusive.
- `Y_MIN`, 30 / `Y_MAX`, 450: vertical bounds, inclusive.
- `X_INIT`, 60 / `Y_INIT`, 60: serve position.
- `PADDLE_W`, 64: paddle width in pixels; used only with `BALL_PADDLE_EN`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: tick-divider enable; low freezes divider and motion.
- `start` in 1: serve request, sampled only in IDLE.
- `vx_in` in VEL_W: horizontal speed, latched at serve.
- `vy_in` in VEL_W: vertical speed, latched at serve.
- `paddle_x` in COORD_W: left edge of paddle.
- `x`, `y` out COORD_W: registered ball position.
- `moving` out 1: high in MOVE.
- `bounce` out 1: one-cycle pulse on any wall or paddle reflection.
- `miss` out 1: one-cycle pulse when the ball passes the paddle.

## Operation
- States:
  - IDLE: ball held at init. `start`=1 latches vx/vy (value 0 is latched as 1), clears the divider, moves to MOVE, sets directions +x,+y.
  - MOVE: on each tick, updates position.
  - MISS: lasts one cycle. Sets x/y to init, then goes to IDLE.
- Divider: counts 0..DIV-1 while `en`=1 in MOVE; `tick` is combinational (counter==DIV-1 && en); counter wraps to 0. In IDLE/MISS the counter is held at 0.
- Per-axis update on tick:
  - Arithmetic is done in COORD_W+1 bits; there is no modular wrap.
  - + direction: cand = pos + v. If cand ≥ MAX, then pos=MAX, dir flips to −.
  - − direction: cand = pos − v (signed extended). If cand ≤ MIN, then pos=MIN, dir flips to +.
  - Otherwise pos = cand.
- Both axes may reflect on the same tick (corner). `bounce` pulses once.
- `start` is ignored outside IDLE. A start in the MISS cycle is ignored.
- Reset: x=X_INIT, y=Y_INIT, dirs +x/+y, vx=vy=1, counter 0, state IDLE, `moving`=0, `bounce`=0, `miss`=0.
- Reset asserted mid-MOVE aborts immediately to reset values, asynchronously.

## Timing
- `start` sampled at edge E0 means `moving`=1 after E0. The first tick is evaluated during the cycle after E3 (DIV=4), so the new x/y are visible after E4, i.e. DIV edges after the start edge.
- `bounce`/`miss` are registered. They assert in the same cycle the new x/y become visible, for exactly one cycle.
- MISS→IDLE takes 1 cycle. x/y show init one cycle after `miss` pulses.
- `en`=0 in MOVE: counter and position are held, and no pulses occur. Resuming continues from the held count.

## Configuration
- `BALL_PADDLE_EN` defined:
  - Bottom reflection (y clamps to Y_MAX) is a paddle hit only if paddle_x ≤ new x ≤ paddle_x+PADDLE_W−1, compared in COORD_W+1 bits using the x value updated on the same tick.
  - Hit: normal reflect, and `bounce` pulses.
  - Otherwise: y=Y_MAX is shown for that cycle with `miss` pulsed, state goes to MISS, and there is no `bounce`.
- Undefined: bottom is a plain wall. `miss` is tied 0 and `paddle_x` is unused.

## Test plan
- Reset: rst_n low then high, en=1, no start for 100 cycles. Expect x=60, y=60, moving=0, no pulses.
- Serve and step (DIV=4): start with vx=3, vy=2. Expect x=63, y=62 exactly 4 edges after the start edge, then +3/+2 every 4 cycles.
- Right wall: x=608 moving +, vx=5. Next tick gives x=610 with bounce for 1 cycle; the tick after gives x=605.
- Corner: x=609, y=449, v=2/2 both +. One tick gives x=610, y=450, a single bounce pulse, and both dirs −.
- Paddle (macro on): y reaches 450 with x=300, paddle_x=280 gives bounce and y decreasing. Repeat with paddle_x=400: miss pulses, then x=60, y=60 and IDLE one cycle later. Macro off: the same stimulus gives bounce and miss=0.
- Freeze/abort: en=0 for 50 cycles mid-MOVE leaves x/y unchanged. Pulsing rst_n low mid-MOVE asynchronously returns x=60, y=60, IDLE.

Source files
------------

// File: rtl/ball_engine.sv
// ball_engine: bouncing-ball motion engine; `BALL_PADDLE_EN` makes the bottom wall a paddle with miss detection.
// Position/pulses update DIV cycles after serve, then every DIV enabled cycles; no backpressure, en=0 freezes motion.
module ball_engine #(
  parameter int COORD_W  = 11,
  parameter int VEL_W    = 3,
  parameter int DIV      = 262144,
  parameter int X_MIN    = 30,
  parameter int X_MAX    = 610,
  parameter int Y_MIN    = 30,
  parameter int Y_MAX    = 450,
  parameter int X_INIT   = 60,
  parameter int Y_INIT   = 60,
  parameter int PADDLE_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               start,
  input  logic [VEL_W-1:0]   vx_in,
  input  logic [VEL_W-1:0]   vy_in,
  input  logic [COORD_W-1:0] paddle_x,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               moving,
  output logic               bounce,
  output logic               miss
);
  localparam int CW    = COORD_W + 1;
  localparam int CNT_W = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_MISS} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [VEL_W-1:0]   r_vx, r_vy;
  logic               r_dx, r_dy;
  logic [COORD_W-1:0] r_x, r_y;
  logic               r_moving, r_bounce, r_miss;

  logic               w_tick;
  logic [COORD_W-1:0] w_nx, w_ny;
  logic               w_ndx, w_ndy, w_rx, w_ry, w_miss;

  // Returns {reflected, new_dir, new_pos}; dir=1 means increasing coordinate.
  function automatic logic [COORD_W+1:0] axis_step(
    input logic [COORD_W-1:0] pos,
    input logic [VEL_W-1:0]   v,
    input logic               dir,
    input int                 lo,
    input int                 hi
  );
    logic [CW-1:0] cand, v_ext, lo_ext, hi_ext;
    v_ext  = CW'(v);
    lo_ext = CW'(lo);
    hi_ext = CW'(hi);
    if (dir) begin
      cand = {1'b0, pos} + v_ext;
      if (cand >= hi_ext) return {1'b1, 1'b0, hi_ext[COORD_W-1:0]};
    end else begin
      cand = {1'b0, pos} - v_ext;
      if ($signed(cand) <= $signed(lo_ext)) return {1'b1, 1'b1, lo_ext[COORD_W-1:0]};
    end
    return {1'b0, dir, cand[COORD_W-1:0]};
  endfunction

  assign w_tick = (r_state == S_MOVE) && en && (r_cnt == CNT_W'(DIV - 1));

  assign {w_rx, w_ndx, w_nx} = axis_step(r_x, r_vx, r_dx, X_MIN, X_MAX);
  assign {w_ry, w_ndy, w_ny} = axis_step(r_y, r_vy, r_dy, Y_MIN, Y_MAX);

`ifdef BALL_PADDLE_EN
  logic [CW-1:0] w_pad_lo, w_pad_hi, w_nx_ext;
  assign w_pad_lo = {1'b0, paddle_x};
  assign w_pad_hi = w_pad_lo + CW'(PADDLE_W - 1);
  assign w_nx_ext = {1'b0, w_nx};
  // Bottom clamp is judged against the x reached on this same tick.
  assign w_miss   = w_ry && r_dy && !((w_nx_ext >= w_pad_lo) && (w_nx_ext <= w_pad_hi));
`else
  logic [CW-1:0] w_unused_paddle;
  assign w_unused_paddle = {1'b0, paddle_x} + CW'(PADDLE_W);
  assign w_miss          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_vx     <= VEL_W'(1);
      r_vy     <= VEL_W'(1);
      r_dx     <= 1'b1;
      r_dy     <= 1'b1;
      r_x      <= COORD_W'(X_INIT);
      r_y      <= COORD_W'(Y_INIT);
      r_moving <= 1'b0;
      r_bounce <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_bounce <= 1'b0;
      r_miss   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_x   <= COORD_W'(X_INIT);
          r_y   <= COORD_W'(Y_INIT);
          r_cnt <= '0;
          if (start) begin
            r_vx     <= (vx_in == '0) ? VEL_W'(1) : vx_in;
            r_vy     <= (vy_in == '0) ? VEL_W'(1) : vy_in;
            r_dx     <= 1'b1;
            r_dy     <= 1'b1;
            r_state  <= S_MOVE;
            r_moving <= 1'b1;
          end
        end
        S_MOVE: begin
          if (en) r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
          if (w_tick) begin
            r_x  <= w_nx;
            r_y  <= w_ny;
            r_dx <= w_ndx;
            r_dy <= w_ndy;
            if (w_miss) begin
              r_miss   <= 1'b1;
              r_state  <= S_MISS;
              r_moving <= 1'b0;
            end else begin
              r_bounce <= w_rx | w_ry;
            end
          end
        end
        S_MISS: begin
          r_x     <= COORD_W'(X_INIT);
          r_y     <= COORD_W'(Y_INIT);
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign moving = r_moving;
  assign bounce = r_bounce;
  assign miss   = r_miss;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with DIV=4 and a square 30..450 playfield so that corners are reachable.
// Expectations are hand-derived; `BALL_PADDLE_EN` selects the paddle-mode expectations.
module tb_ball_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  vx_in = '0;
  logic [2:0]  vy_in = '0;
  logic [10:0] paddle_x = '0;
  logic [10:0] x, y;
  logic        moving, bounce, miss;

  int n_assert = 0;
  int n_fail   = 0;
  int n_bounce = 0;
  int n_miss   = 0;
  int nb0      = 0;

  ball_engine #(
    .COORD_W(11), .VEL_W(3), .DIV(4),
    .X_MIN(30), .X_MAX(450), .Y_MIN(30), .Y_MAX(450),
    .X_INIT(60), .Y_INIT(60), .PADDLE_W(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start),
    .vx_in(vx_in), .vy_in(vy_in), .paddle_x(paddle_x),
    .x(x), .y(y), .moving(moving), .bounce(bounce), .miss(miss)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bounce === 1'b1) n_bounce++;
    if (miss === 1'b1) n_miss++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, "_x"}, 32'(x), ex);
    check({tag, "_y"}, 32'(y), ey);
  endtask

  task automatic serve(input logic [2:0] vx, input logic [2:0] vy);
    vx_in = vx;
    vy_in = vy;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset and idle
    en = 1'b1;
    step(3);
    check_pos("in_rst", 60, 60);
    rst_n = 1'b1;
    step(100);
    check_pos("idle", 60, 60);
    check("idle_moving", 32'(moving), 0);
    check("idle_pulses", n_bounce + n_miss, 0);

    // Serve, first tick latency, start ignored in MOVE, freeze, async abort
    serve(3'd3, 3'd2);
    check("srv_moving", 32'(moving), 1);
    check_pos("srv_e0", 60, 60);
    step(3);
    check_pos("srv_e3", 60, 60);
    step(1);
    check_pos("srv_e4", 63, 62);
    check("srv_e4_bounce", 32'(bounce), 0);
    start = 1'b1; vx_in = 3'd7; vy_in = 3'd7;
    step(4);
    start = 1'b0;
    check_pos("srv_e8", 66, 64);
    step(1);
    en = 1'b0;
    nb0 = n_bounce + n_miss;
    step(50);
    check_pos("frz", 66, 64);
    check("frz_moving", 32'(moving), 1);
    en = 1'b1;
    step(2);
    check_pos("frz_resume2", 66, 64);
    step(1);
    check_pos("frz_resume3", 69, 66);
    check("frz_pulses", n_bounce + n_miss - nb0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_pos("abort", 60, 60);
    check("abort_moving", 32'(moving), 0);
    rst_n = 1'b1;
    step(1);
    check_pos("abort_idle", 60, 60);
    check("abort_idle_moving", 32'(moving), 0);

    // Right wall with overshoot, then left wall exact hit
    serve(3'd4, 3'd1);
    step(388);
    check_pos("rw_t97", 448, 157);
    check("rw_t97_bounce", 32'(bounce), 0);
    nb0 = n_bounce;
    step(4);
    check_pos("rw_t98", 450, 158);
    check("rw_t98_bounce", 32'(bounce), 1);
    step(1);
    check("rw_bounce_len", 32'(bounce), 0);
    step(3);
    check_pos("rw_t99", 446, 159);
    check("rw_pulse_cnt", n_bounce - nb0, 1);
    step(412);
    check_pos("lw_t202", 34, 262);
    step(4);
    check_pos("lw_t203", 30, 263);
    check("lw_t203_bounce", 32'(bounce), 1);
    step(4);
    check_pos("lw_t204", 34, 264);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);

    // Corners; bottom corner is a paddle hit at the paddle's right edge
    paddle_x = 11'd387;
    serve(3'd7, 3'd7);
    step(220);
    check_pos("cn_t55", 445, 445);
    nb0 = n_bounce;
    step(4);
    check_pos("cn_t56", 450, 450);
    check("cn_t56_bounce", 32'(bounce), 1);
    check("cn_t56_miss", 32'(miss), 0);
    step(1);
    check("cn_bounce_len", 32'(bounce), 0);
    step(3);
    check_pos("cn_t57", 443, 443);
    check("cn_pulse_cnt", n_bounce - nb0, 1);
    step(232);
    check_pos("tl_t115", 37, 37);
    step(4);
    check_pos("tl_t116", 30, 30);
    check("tl_t116_bounce", 32'(bounce), 1);
    step(4);
    check_pos("tl_t117", 37, 37);
    step(232);
    check_pos("bt_t175", 443, 443);
    paddle_x = 11'd451;
    step(4);
    check_pos("bt_t176", 450, 450);
`ifdef BALL_PADDLE_EN
    check("bt_miss", 32'(miss), 1);
    check("bt_no_bounce", 32'(bounce), 0);
    check("bt_miss_moving", 32'(moving), 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_pos("bt_after_miss", 60, 60);
    check("bt_miss_len", 32'(miss), 0);
    step(1);
    check("bt_idle_moving", 32'(moving), 0);
    check_pos("bt_idle", 60, 60);
`else
    check("bt_bounce", 32'(bounce), 1);
    check("bt_miss_tied", 32'(miss), 0);
    step(4);
    check_pos("bt_t177", 443, 443);
    check("bt_miss_total", n_miss, 0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
`endif

    // Zero speed is served as speed 1
    serve(3'd0, 3'd0);
    step(4);
    check_pos("zero_v", 61, 61);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
